mem_compare_engine: RTL and testbench

- Hardware result checker that scans an address range of two SRAM_Memory instances (DUT result memory and golden reference memory) and reports the mismatch count and first failing address.
- Parametrised successor of the software compare loop used in our shortest-path benches.
- Sits beside ShortestPath_N cores on the P-memory read side.
- Runs pipelined at one word per clock, with a Go/Done handshake matching the core's.

---
 rtl/mem_cmp_pkg.sv | 17 +
 rtl/mem_compare_engine_if.sv | 42 ++++
 rtl/mem_cmp_pipe.sv | 43 ++++
 rtl/mem_compare_engine.sv | 174 +++++++++++++++++
 tb/tb_mem_compare_engine.sv | 261 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_cmp_pkg.sv
// Shared constants for the memory compare engine: FSM state encoding,
// default data-path widths and the supported read-latency limit.
package mem_cmp_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_READ  = 2'd1;
    localparam state_t ST_DRAIN = 2'd2;
    localparam state_t ST_DONE  = 2'd3;

    localparam int DEF_A_WIDTH   = 13;
    localparam int DEF_D_WIDTH   = 8;
    localparam int DEF_CNT_WIDTH = 14;
    localparam int MAX_READ_LAT  = 4;

endpackage

// File: rtl/mem_compare_engine_if.sv
// Control/status and dual-memory read bus of the compare engine.
// slave  : the engine side (drives addresses/enables and status)
// master : the host/memory side (drives Go, range, mask and read data)
interface mem_compare_engine_if
    import mem_cmp_pkg::*;
#(
    parameter int A_WIDTH   = DEF_A_WIDTH,
    parameter int D_WIDTH   = DEF_D_WIDTH,
    parameter int CNT_WIDTH = DEF_CNT_WIDTH
);
    logic                 Go;
    logic [A_WIDTH-1:0]   Start_Addr;
    logic [A_WIDTH-1:0]   End_Addr;
    logic [D_WIDTH-1:0]   Mask;
    logic [A_WIDTH-1:0]   D_Addr;
    logic [A_WIDTH-1:0]   R_Addr;
    logic                 D_En;
    logic                 R_En;
    logic                 D_Rw;
    logic                 R_Rw;
    logic [D_WIDTH-1:0]   D_Data;
    logic [D_WIDTH-1:0]   R_Data;
    logic                 Busy;
    logic                 Done;
    logic                 Pass;
    logic [CNT_WIDTH-1:0] Err_Count;
    logic [A_WIDTH-1:0]   First_Err_Addr;
    logic                 First_Err_Valid;

    modport slave (
        input  Go, Start_Addr, End_Addr, Mask, D_Data, R_Data,
        output D_Addr, R_Addr, D_En, R_En, D_Rw, R_Rw,
        output Busy, Done, Pass, Err_Count, First_Err_Addr, First_Err_Valid
    );

    modport master (
        output Go, Start_Addr, End_Addr, Mask, D_Data, R_Data,
        input  D_Addr, R_Addr, D_En, R_En, D_Rw, R_Rw,
        input  Busy, Done, Pass, Err_Count, First_Err_Addr, First_Err_Valid
    );

endinterface

// File: rtl/mem_cmp_pipe.sv
// Valid + address delay line. An address issued to the memories enters
// stage 0 on the issuing edge and leaves stage DEPTH-1 in the same cycle
// that the memories present its read data.
module mem_cmp_pipe
    import mem_cmp_pkg::*;
#(
    parameter int A_WIDTH = DEF_A_WIDTH,
    parameter int DEPTH   = 1
)(
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    input  logic [A_WIDTH-1:0] in_addr,
    output logic               out_valid,
    output logic [A_WIDTH-1:0] out_addr,
    output logic               any_valid
);

    logic [DEPTH-1:0]   valid_r;
    logic [A_WIDTH-1:0] addr_r [DEPTH];

    // Shift valid flags and addresses one stage per clock.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_r <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                addr_r[i] <= '0;
            end
        end else begin
            valid_r[0] <= in_valid;
            addr_r[0]  <= in_addr;
            for (int i = 1; i < DEPTH; i++) begin
                valid_r[i] <= valid_r[i-1];
                addr_r[i]  <= addr_r[i-1];
            end
        end
    end

    assign out_valid = valid_r[DEPTH-1];
    assign out_addr  = addr_r[DEPTH-1];
    assign any_valid = |valid_r;

endmodule

// File: rtl/mem_compare_engine.sv
// Memory compare engine: streams one address per clock to a DUT result
// memory and a golden reference memory, compares the returned words under
// a bit mask and reports mismatch count and first failing address.
// Optional build macro MEM_CMP_STOP_ON_ERR_EN: stop issuing reads at the
// first registered mismatch (words already in flight are still compared).
module mem_compare_engine
    import mem_cmp_pkg::*;
#(
    parameter int A_WIDTH   = DEF_A_WIDTH,
    parameter int D_WIDTH   = DEF_D_WIDTH,
    parameter int READ_LAT  = 1,
    parameter int CNT_WIDTH = DEF_CNT_WIDTH
)(
    input logic                  Clk,
    input logic                  Rst,
    mem_compare_engine_if.slave  bus
);

    // Out-of-range latencies are clamped to the supported 1..MAX_READ_LAT.
    localparam int LAT = (READ_LAT < 1) ? 1 :
                         ((READ_LAT > MAX_READ_LAT) ? MAX_READ_LAT : READ_LAT);

    function automatic logic word_mismatch(input logic [D_WIDTH-1:0] d,
                                           input logic [D_WIDTH-1:0] r,
                                           input logic [D_WIDTH-1:0] m);
        return |((d ^ r) & m);
    endfunction

    state_t               state_r;
    state_t               state_nxt_s;
    logic [A_WIDTH-1:0]   addr_r;
    logic [A_WIDTH-1:0]   end_r;
    logic [D_WIDTH-1:0]   mask_r;
    logic                 cmp_valid_r;
    logic                 cmp_mis_r;
    logic [A_WIDTH-1:0]   cmp_addr_r;
    logic [CNT_WIDTH-1:0] err_count_r;
    logic [A_WIDTH-1:0]   first_addr_r;
    logic                 first_valid_r;
    logic                 pipe_valid_s;
    logic [A_WIDTH-1:0]   pipe_addr_s;
    logic                 pipe_any_s;
    logic                 go_s;
    logic                 stop_s;
    logic                 issue_s;

    assign go_s = bus.Go && ((state_r == ST_IDLE) || (state_r == ST_DONE));

`ifdef MEM_CMP_STOP_ON_ERR_EN
    // A mismatch sitting in the compare stage blocks further reads at once.
    assign stop_s = cmp_valid_r && cmp_mis_r;
`else
    assign stop_s = 1'b0;
`endif

    assign issue_s = (state_r == ST_READ) && !stop_s;

    // Next-state decode for the scan sequencer.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE, ST_DONE: begin
                if (go_s) begin
                    state_nxt_s = (bus.Start_Addr > bus.End_Addr) ? ST_DONE : ST_READ;
                end else begin
                    state_nxt_s = state_r;
                end
            end
            ST_READ: begin
                if (stop_s || (addr_r == end_r)) begin
                    state_nxt_s = ST_DRAIN;
                end else begin
                    state_nxt_s = ST_READ;
                end
            end
            ST_DRAIN: begin
                if (!pipe_any_s && !cmp_valid_r) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_DRAIN;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Latch range and mask on Go; step the address while issuing, holding
    // at End_Addr so the counter never wraps.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            addr_r <= '0;
            end_r  <= '0;
            mask_r <= '0;
        end else if (go_s) begin
            addr_r <= bus.Start_Addr;
            end_r  <= bus.End_Addr;
            mask_r <= bus.Mask;
        end else if (issue_s && (addr_r != end_r)) begin
            addr_r <= addr_r + A_WIDTH'(1);
        end
    end

    mem_cmp_pipe #(
        .A_WIDTH (A_WIDTH),
        .DEPTH   (LAT)
    ) u_pipe (
        .clk       (Clk),
        .rst       (Rst),
        .in_valid  (issue_s),
        .in_addr   (addr_r),
        .out_valid (pipe_valid_s),
        .out_addr  (pipe_addr_s),
        .any_valid (pipe_any_s)
    );

    // Registered masked compare of the word leaving the delay line.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            cmp_valid_r <= 1'b0;
            cmp_mis_r   <= 1'b0;
            cmp_addr_r  <= '0;
        end else begin
            cmp_valid_r <= pipe_valid_s;
            cmp_mis_r   <= word_mismatch(bus.D_Data, bus.R_Data, mask_r);
            cmp_addr_r  <= pipe_addr_s;
        end
    end

    // Saturating mismatch counter and first-failure capture.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            err_count_r   <= '0;
            first_addr_r  <= '0;
            first_valid_r <= 1'b0;
        end else if (go_s) begin
            err_count_r   <= '0;
            first_addr_r  <= '0;
            first_valid_r <= 1'b0;
        end else if (cmp_valid_r && cmp_mis_r) begin
            if (err_count_r != {CNT_WIDTH{1'b1}}) begin
                err_count_r <= err_count_r + CNT_WIDTH'(1);
            end
            if (!first_valid_r) begin
                first_addr_r  <= cmp_addr_r;
                first_valid_r <= 1'b1;
            end
        end
    end

    assign bus.D_Addr          = addr_r;
    assign bus.R_Addr          = addr_r;
    assign bus.D_En            = issue_s;
    assign bus.R_En            = issue_s;
    assign bus.D_Rw            = 1'b0;
    assign bus.R_Rw            = 1'b0;
    assign bus.Busy            = (state_r == ST_READ) || (state_r == ST_DRAIN);
    assign bus.Done            = (state_r == ST_DONE);
    assign bus.Pass            = (state_r == ST_DONE) && (err_count_r == '0);
    assign bus.Err_Count       = err_count_r;
    assign bus.First_Err_Addr  = first_addr_r;
    assign bus.First_Err_Valid = first_valid_r;

endmodule

// File: tb/tb_mem_compare_engine.sv
// Self-checking bench for mem_compare_engine. Two engines share the memory
// images: u_dut1 (READ_LAT=1, 14-bit count) and u_dut3 (READ_LAT=3, 3-bit
// count so saturation is reachable). Directed vectors live in a table.
module tb_mem_compare_engine;
    import mem_cmp_pkg::*;

    localparam int AW = 13;
    localparam int DW = 8;

    logic Clk = 1'b0;
    logic Rst = 1'b1;
    always #5 Clk = ~Clk;

    mem_compare_engine_if #(.A_WIDTH(AW), .D_WIDTH(DW), .CNT_WIDTH(14)) if1 ();
    mem_compare_engine_if #(.A_WIDTH(AW), .D_WIDTH(DW), .CNT_WIDTH(3))  if3 ();

    mem_compare_engine #(.A_WIDTH(AW), .D_WIDTH(DW), .READ_LAT(1), .CNT_WIDTH(14)) u_dut1 (
        .Clk (Clk), .Rst (Rst), .bus (if1.slave));
    mem_compare_engine #(.A_WIDTH(AW), .D_WIDTH(DW), .READ_LAT(3), .CNT_WIDTH(3)) u_dut3 (
        .Clk (Clk), .Rst (Rst), .bus (if3.slave));

    logic [7:0] dmem [0:8191];
    logic [7:0] rmem [0:8191];
    logic [7:0] d1_q = 8'h00, r1_q = 8'h00;
    logic [7:0] d3_q [3];
    logic [7:0] r3_q [3];

    // SRAM models: latency 1 for u_dut1, latency 3 for u_dut3.
    always @(posedge Clk) begin
        if (if1.D_En) d1_q <= dmem[if1.D_Addr];
        if (if1.R_En) r1_q <= rmem[if1.R_Addr];
        if (if3.D_En) d3_q[0] <= dmem[if3.D_Addr];
        if (if3.R_En) r3_q[0] <= rmem[if3.R_Addr];
        d3_q[1] <= d3_q[0];
        d3_q[2] <= d3_q[1];
        r3_q[1] <= r3_q[0];
        r3_q[2] <= r3_q[1];
    end

    assign if1.D_Data = d1_q;
    assign if1.R_Data = r1_q;
    assign if3.D_Data = d3_q[2];
    assign if3.R_Data = r3_q[2];

    // Read monitor: counts reads and flags ones outside the active range.
    int rd_total = 0;
    int rd_bad   = 0;
    int last_rd  = 0;
    int cur_lo   = 0;
    int cur_hi   = 0;
    int cur_sel  = 1;
    always @(posedge Clk) begin
        if (if1.D_En) begin
            rd_total <= rd_total + 1;
            last_rd  <= int'(if1.D_Addr);
            if (int'(if1.D_Addr) < cur_lo || int'(if1.D_Addr) > cur_hi ||
                if1.R_Addr != if1.D_Addr || !if1.R_En || if1.D_Rw || if1.R_Rw)
                rd_bad <= rd_bad + 1;
        end else if (if3.D_En) begin
            rd_total <= rd_total + 1;
            last_rd  <= int'(if3.D_Addr);
            if (int'(if3.D_Addr) < cur_lo || int'(if3.D_Addr) > cur_hi ||
                if3.R_Addr != if3.D_Addr || !if3.R_En || if3.D_Rw || if3.R_Rw)
                rd_bad <= rd_bad + 1;
        end
    end

    logic done_s, busy_s, pass_s, fev_s, en_s;
    int   err_s, fea_s;
    assign done_s = (cur_sel == 3) ? if3.Done : if1.Done;
    assign busy_s = (cur_sel == 3) ? if3.Busy : if1.Busy;
    assign pass_s = (cur_sel == 3) ? if3.Pass : if1.Pass;
    assign fev_s  = (cur_sel == 3) ? if3.First_Err_Valid : if1.First_Err_Valid;
    assign en_s   = (cur_sel == 3) ? if3.D_En : if1.D_En;
    assign err_s  = (cur_sel == 3) ? int'(if3.Err_Count) : int'(if1.Err_Count);
    assign fea_s  = (cur_sel == 3) ? int'(if3.First_Err_Addr) : int'(if1.First_Err_Addr);

    int n_tests = 0;
    int n_fail  = 0;
    int rd_snap = 0;
    int bad_snap = 0;

    task automatic chk(input string nm, input longint got, input longint exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, got, exp);
        end
    endtask

    task automatic start_run(input int sel, input int s, input int e, input logic [7:0] m);
        @(negedge Clk);
        cur_sel = sel; cur_lo = s; cur_hi = e;
        rd_snap = rd_total; bad_snap = rd_bad;
        if1.Start_Addr = AW'(s); if1.End_Addr = AW'(e); if1.Mask = m;
        if3.Start_Addr = AW'(s); if3.End_Addr = AW'(e); if3.Mask = m;
        if (sel == 3) if3.Go = 1'b1; else if1.Go = 1'b1;
        @(posedge Clk);
        #1;
        if1.Go = 1'b0; if3.Go = 1'b0;
    endtask

    // Counts edges after the Go-sampling edge until Done is seen.
    task automatic wait_done(input int budget, output int edges, output bit ok);
        edges = 0;
        while (!done_s && edges < budget) begin
            @(posedge Clk);
            #1;
            edges++;
        end
        ok = done_s;
    endtask

    task automatic check_result(input string nm, input int got_edges, input bit ok,
                                input int x_edges, input int x_err, input int x_fea,
                                input int x_fev, input int x_pass, input int x_reads,
                                input int x_last);
        if (!ok) begin
            chk({nm, ".done_timeout"}, 0, 1);
            return;
        end
        chk({nm, ".edges"}, got_edges, x_edges);
        chk({nm, ".err"}, err_s, x_err);
        chk({nm, ".first_addr"}, fea_s, x_fea);
        chk({nm, ".first_valid"}, fev_s, x_fev);
        chk({nm, ".pass"}, pass_s, x_pass);
        chk({nm, ".busy"}, busy_s, 0);
        chk({nm, ".reads"}, rd_total - rd_snap, x_reads);
        if (x_reads > 0) chk({nm, ".last_read"}, last_rd, x_last);
        chk({nm, ".bad_reads"}, rd_bad - bad_snap, 0);
    endtask

    typedef struct {
        int sel; int s; int e; logic [7:0] m;
        int err; int fea; int fev; int pass; int edges; int reads; int last;
    } vec_t;

    vec_t vt [12];
    int   edges;
    bit   ok;

    initial begin
        for (int i = 0; i < 8192; i++) begin
            rmem[i] = 8'(i * 7 + 3);
            dmem[i] = rmem[i];
        end
        if1.Go = 1'b0; if1.Start_Addr = '0; if1.End_Addr = '0; if1.Mask = '0;
        if3.Go = 1'b0; if3.Start_Addr = '0; if3.End_Addr = '0; if3.Mask = '0;

        // Reset state.
        #3;
        chk("rst.busy", if1.Busy, 0);
        chk("rst.done", if1.Done, 0);
        chk("rst.pass", if1.Pass, 0);
        chk("rst.err", if1.Err_Count, 0);
        chk("rst.first_valid", if1.First_Err_Valid, 0);
        chk("rst.first_addr", if1.First_Err_Addr, 0);
        chk("rst.en", if1.D_En, 0);
        chk("rst.en3", if3.D_En, 0);
        @(negedge Clk);
        Rst = 1'b0;

        // Identical memories, full range.
        start_run(1, 0, 8191, 8'hFF);
        chk("ident.busy_after_go", busy_s, 1);
        wait_done(8300, edges, ok);
        check_result("ident", edges, ok, 8195, 0, 0, 0, 1, 8192, 8191);

        // Plant differences.
        dmem[5]    = dmem[5]    ^ 8'h01;
        dmem[20]   = dmem[20]   ^ 8'h80;
        dmem[100]  = dmem[100]  ^ 8'h10;
        dmem[8191] = dmem[8191] ^ 8'h02;

        // Asynchronous reset in the middle of a run.
        start_run(1, 0, 8191, 8'hFF);
        repeat (50) @(posedge Clk);
        #1;
        chk("midrst.busy_before", busy_s, 1);
        chk("midrst.err_before", err_s, 2);
        #2 Rst = 1'b1;
        #1;
        chk("midrst.busy", busy_s, 0);
        chk("midrst.done", done_s, 0);
        chk("midrst.err", err_s, 0);
        chk("midrst.en", en_s, 0);
        chk("midrst.first_valid", fev_s, 0);
        @(negedge Clk);
        Rst = 1'b0;
        repeat (4) @(posedge Clk);
        #1;
        chk("midrst.no_partial_done", done_s, 0);

        //        sel  s     e     mask   err fea   fev pass edges reads last
        vt[0]  = '{1,  0,    8191, 8'hFF, 4,  5,    1,  0,   8195, 8192, 8191};
        vt[1]  = '{1,  0,    8191, 8'h7F, 3,  5,    1,  0,   8195, 8192, 8191};
        vt[2]  = '{1,  15,   25,   8'h7F, 0,  0,    0,  1,   14,   11,   25};
        vt[3]  = '{1,  15,   25,   8'hFF, 1,  20,   1,  0,   14,   11,   25};
        vt[4]  = '{3,  90,   110,  8'hFF, 1,  100,  1,  0,   26,   21,   110};
        vt[5]  = '{3,  8000, 8191, 8'hFF, 1,  8191, 1,  0,   197,  192,  8191};
        vt[6]  = '{1,  5,    5,    8'hFF, 1,  5,    1,  0,   4,    1,    5};
        vt[7]  = '{3,  6,    6,    8'hFF, 0,  0,    0,  1,   6,    1,    6};
        vt[8]  = '{1,  10,   3,    8'hFF, 0,  0,    0,  1,   0,    0,    0};
        vt[9]  = '{3,  8191, 8191, 8'h02, 1,  8191, 1,  0,   6,    1,    8191};
        vt[10] = '{1,  0,    4,    8'hFF, 0,  0,    0,  1,   8,    5,    4};
        vt[11] = '{3,  0,    30,   8'hFE, 1,  20,   1,  0,   36,   31,   30};

        for (int i = 0; i < 12; i++) begin
            start_run(vt[i].sel, vt[i].s, vt[i].e, vt[i].m);
            wait_done(vt[i].edges + 40, edges, ok);
            check_result($sformatf("vec%0d", i), edges, ok, vt[i].edges, vt[i].err,
                         vt[i].fea, vt[i].fev, vt[i].pass, vt[i].reads, vt[i].last);
        end

        // Go while busy is ignored: second Go asks for a different range.
        start_run(1, 15, 25, 8'hFF);
        repeat (3) @(posedge Clk);
        @(negedge Clk);
        if1.Start_Addr = AW'(0); if1.End_Addr = AW'(8191); if1.Mask = 8'h7F;
        if1.Go = 1'b1;
        @(posedge Clk);
        #1;
        if1.Go = 1'b0;
        begin
            int more;
            wait_done(100, more, ok);
            edges = more + 4;
        end
        check_result("go_busy", edges, ok, 14, 1, 20, 1, 0, 11, 25);

        // Go in DONE restarts at once and clears results.
        @(negedge Clk);
        if1.Start_Addr = AW'(15); if1.End_Addr = AW'(25); if1.Mask = 8'h7F;
        rd_snap = rd_total; bad_snap = rd_bad;
        if1.Go = 1'b1;
        @(posedge Clk);
        #1;
        if1.Go = 1'b0;
        chk("restart.done_falls", done_s, 0);
        chk("restart.busy", busy_s, 1);
        chk("restart.err_clear", err_s, 0);
        chk("restart.first_valid_clear", fev_s, 0);
        wait_done(100, edges, ok);
        check_result("restart", edges, ok, 14, 0, 0, 0, 1, 11, 25);

        // Burst of mismatches at 40..60 on the latency-3 engine.
        for (int a = 40; a <= 60; a++) dmem[a] = dmem[a] ^ 8'h0F;
        start_run(3, 30, 90, 8'hFF);
        wait_done(200, edges, ok);
`ifdef MEM_CMP_STOP_ON_ERR_EN
        check_result("burst", edges, ok, 19, 4, 40, 1, 0, 14, 43);
`else
        check_result("burst", edges, ok, 66, 7, 40, 1, 0, 61, 90);
`endif
        for (int a = 40; a <= 60; a++) dmem[a] = dmem[a] ^ 8'h0F;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
